// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions: response codes, arbiter state encoding and a
// small index-width helper used by the arbiter and its picker.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_ADDR = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    // Width of a requester index; at least one bit so a single requester still works.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_rr_arbiter_if.sv
// AXI-lite bundle with N lanes of AR/AW/W/R/B handshakes. Address, prot,
// data and strobe are packed per lane (lane i at slice i); R/B payloads are
// single-width because they are broadcast to every lane.
interface axi_lite_rr_arbiter_if #(
    parameter int unsigned N      = 1,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [N-1:0]        ar_valid;
    logic [N*ADDR_W-1:0] ar_addr;
    logic [N*3-1:0]      ar_prot;
    logic [N-1:0]        ar_ready;

    logic [N-1:0]        aw_valid;
    logic [N*ADDR_W-1:0] aw_addr;
    logic [N*3-1:0]      aw_prot;
    logic [N-1:0]        aw_ready;

    logic [N-1:0]        w_valid;
    logic [N*DATA_W-1:0] w_data;
    logic [N*STRB_W-1:0] w_strb;
    logic [N-1:0]        w_ready;

    logic [N-1:0]        r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic [N-1:0]        r_ready;

    logic [N-1:0]        b_valid;
    logic [1:0]          b_resp;
    logic [N-1:0]        b_ready;

    // Bus master: issues requests, accepts responses.
    modport master (
        output ar_valid, ar_addr, ar_prot, input  ar_ready,
        output aw_valid, aw_addr, aw_prot, input  aw_ready,
        output w_valid,  w_data,  w_strb,  input  w_ready,
        input  r_valid,  r_data,  r_resp,  output r_ready,
        input  b_valid,  b_resp,           output b_ready
    );

    // Bus slave: accepts requests, returns responses.
    modport slave (
        input  ar_valid, ar_addr, ar_prot, output ar_ready,
        input  aw_valid, aw_addr, aw_prot, output aw_ready,
        input  w_valid,  w_data,  w_strb,  output w_ready,
        output r_valid,  r_data,  r_resp,  input  r_ready,
        output b_valid,  b_resp,           input  b_ready
    );

endinterface

// File: rtl/arb_rr_pick.sv
// Combinational rotating-priority picker. The search starts one past 'last'
// and wraps; tying last to NUM_REQ-1 gives plain lowest-index-wins priority.
module arb_rr_pick
    import axi_lite_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic found;

    // First pass covers indices above last, second pass wraps to 0..last.
    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i > int'(last))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i <= int'(last))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// N-requester to 1-slave AXI-lite arbiter. A grant is held for one whole
// transaction (address through R or B handshake); one transaction at a time.
// Define AXI_ARB_RR_EN for round-robin; otherwise fixed priority, index 0 wins.
module axi_lite_rr_arbiter
    import axi_lite_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    axi_lite_rr_arbiter_if.slave  s,
    axi_lite_rr_arbiter_if.master m,
    output logic                  busy
);

    localparam int unsigned IDX_W  = idx_w(NUM_REQ);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [2:0]         state_q, state_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   pick_last;
    logic [31:0]        sel;

`ifdef AXI_ARB_RR_EN
    logic [IDX_W-1:0]   last_q, last_d;
    assign pick_last = last_q;
`else
    assign pick_last = IDX_W'(NUM_REQ - 1);
`endif

    assign req  = s.ar_valid | s.aw_valid;
    assign sel  = 32'(gnt_q);
    assign busy = (state_q != IDLE);

    arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .last  (pick_last),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Route the granted requester's channels to the master port; all else reads 0.
    always_comb begin
        s.ar_ready = '0;
        s.aw_ready = '0;
        s.w_ready  = '0;
        s.r_valid  = '0;
        s.b_valid  = '0;
        s.r_data   = m.r_data;
        s.r_resp   = m.r_resp;
        s.b_resp   = m.b_resp;
        m.ar_valid = 1'b0;
        m.ar_addr  = '0;
        m.ar_prot  = '0;
        m.aw_valid = 1'b0;
        m.aw_addr  = '0;
        m.aw_prot  = '0;
        m.w_valid  = 1'b0;
        m.w_data   = '0;
        m.w_strb   = '0;
        m.r_ready  = 1'b0;
        m.b_ready  = 1'b0;
        case (state_q)
            RD_ADDR: begin
                m.ar_valid        = s.ar_valid[gnt_q];
                s.ar_ready[gnt_q] = m.ar_ready;
                if (m.ar_valid) begin
                    m.ar_addr = s.ar_addr[sel*ADDR_W +: ADDR_W];
                    m.ar_prot = s.ar_prot[sel*3 +: 3];
                end
            end
            RD_DATA: begin
                m.r_ready        = s.r_ready[gnt_q];
                s.r_valid[gnt_q] = m.r_valid;
            end
            WR_ADDR: begin
                if (!aw_done_q) begin
                    m.aw_valid        = s.aw_valid[gnt_q];
                    s.aw_ready[gnt_q] = m.aw_ready;
                    if (m.aw_valid) begin
                        m.aw_addr = s.aw_addr[sel*ADDR_W +: ADDR_W];
                        m.aw_prot = s.aw_prot[sel*3 +: 3];
                    end
                end
                if (!w_done_q) begin
                    m.w_valid        = s.w_valid[gnt_q];
                    s.w_ready[gnt_q] = m.w_ready;
                    if (m.w_valid) begin
                        m.w_data = s.w_data[sel*DATA_W +: DATA_W];
                        m.w_strb = s.w_strb[sel*STRB_W +: STRB_W];
                    end
                end
            end
            WR_RESP: begin
                m.b_ready        = s.b_ready[gnt_q];
                s.b_valid[gnt_q] = m.b_valid;
            end
            default: ;
        endcase
    end

    // Transaction sequencing: arbitrate in IDLE, then follow the granted transaction.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef AXI_ARB_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d     = pick_idx;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    // A requester raising both AR and AW is served read first.
                    state_d   = (|(pick_grant & s.ar_valid)) ? RD_ADDR : WR_ADDR;
                end
            end
            RD_ADDR: begin
                if (m.ar_valid && m.ar_ready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (m.r_valid && m.r_ready) begin
                    state_d = IDLE;
`ifdef AXI_ARB_RR_EN
                    last_d  = gnt_q;
`endif
                end
            end
            WR_ADDR: begin
                if (m.aw_valid && m.aw_ready) aw_done_d = 1'b1;
                if (m.w_valid && m.w_ready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)    state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (m.b_valid && m.b_ready) begin
                    state_d = IDLE;
`ifdef AXI_ARB_RR_EN
                    last_d  = gnt_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset abandons any transaction.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef AXI_ARB_RR_EN
            last_q    <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef AXI_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

endmodule
